pulse_gen: RTL and testbench
============================

// Module: pulse_gen
//
// PURPOSE
//   Pulse train generator: on a start strobe, emits exactly N clean rectangular
//   pulses of fixed high/low width on o_pulse, then strobes o_done.
//   Transmit-side counterpart to the rising-edge pulse counter (pulse_cnt).
//   Used to drive counted event lines and as a stimulus source in loopback tests.
//
// PARAMETERS
//   BITS       8  width of the pulse-count request i_data (max 2**BITS-1 pulses)
//   HI_CYCLES  4  clocks o_pulse stays high per pulse (>=1)
//   LO_CYCLES  4  clocks o_pulse stays low after each pulse (>=1)
//
// PORTS
//   i_clk    in   1     system clock, all state on posedge
//   i_rst    in   1     asynchronous, active-high reset
//   i_wr     in   1     start strobe; i_data sampled when i_wr=1 and o_busy=0
//   i_data   in   BITS  number of pulses to emit (0 is legal)
//   o_pulse  out  1     generated pulse train (registered)
//   o_busy   out  1     1 while a train is in progress (registered)
//   o_done   out  1     one-cycle strobe when a request completes (registered)
//
// BEHAVIOUR
//   - Reset (async, any time): o_pulse=0, o_busy=0, o_done=0, state IDLE,
//     remaining-count and phase timer cleared; in-progress train abandoned,
//     no o_done for it.
//   - FSM states: IDLE, HIGH, LOW. Phase timer width $clog2(max(HI,LO)+1);
//     remaining counter BITS wide.
//   - IDLE, i_wr=1, i_data=N>0: next edge -> HIGH, o_pulse=1, o_busy=1,
//     remaining=N. Rising edge of o_pulse is visible the cycle after i_wr.
//   - IDLE, i_wr=1, i_data=0: no pulse, o_busy stays 0, o_done=1 next cycle.
//   - HIGH: o_pulse=1 for exactly HI_CYCLES clocks, then LOW; remaining
//     decremented on the HIGH->LOW transition.
//   - LOW: o_pulse=0 for exactly LO_CYCLES clocks; then remaining>0 -> HIGH,
//     remaining=0 -> IDLE with o_busy=0 and o_done=1 for one cycle.
//   - The final LOW phase is always completed before o_done (guaranteed
//     spacing for a downstream edge counter).
//   - Train length: N*(HI_CYCLES+LO_CYCLES) clocks of o_busy=1; o_done in the
//     first cycle after o_busy falls.
//   - i_wr while o_busy=1: ignored, i_data not sampled, train unaffected.
//   - i_wr in the same cycle o_done=1 (state IDLE): accepted normally;
//     back-to-back requests give HI..LO..HI with no extra gap.
//   - N=2**BITS-1 must complete without counter wrap.
//
// TESTING
//   1. Assert i_rst mid-cycle, no clock -> o_pulse=o_busy=o_done=0 immediately.
//   2. HI=2,LO=3, i_data=3 one-cycle i_wr -> pulses high cycles 1-2,6-7,11-12;
//      o_busy cycles 1-15; o_done only at cycle 16.
//   3. i_data=0 -> no o_pulse high, o_busy stays 0, o_done single cycle after i_wr.
//   4. Loopback into pulse_cnt (BITS=8), i_data=200 -> counter advances by 200
//      exactly; second request of 100 on o_done cycle -> total 300 mod 256 = 44.
//   5. i_wr with i_data=9 during busy of N=2 train -> exactly 2 pulses, one o_done.
//   6. i_rst asserted during 2nd pulse of N=5 -> outputs 0 at once, no o_done;
//      new request N=1 after release -> exactly 1 pulse, then o_done.

Source files
------------

// File: rtl/pulse_gen.sv
// Pulse train generator: a start strobe launches N pulses of HI_CYCLES high / LO_CYCLES low; first rising edge one clock after i_wr.
// No backpressure: requests arriving while o_busy=1 are dropped; o_done strobes one clock after the final low phase ends.
module pulse_gen #(
  parameter int BITS      = 8,
  parameter int HI_CYCLES = 4,
  parameter int LO_CYCLES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr,
  input  logic [BITS-1:0] i_data,
  output logic            o_pulse,
  output logic            o_busy,
  output logic            o_done
);

  localparam int MAX_CYCLES = (HI_CYCLES > LO_CYCLES) ? HI_CYCLES : LO_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] HI_LAST = TW'(HI_CYCLES - 1);
  localparam logic [TW-1:0] LO_LAST = TW'(LO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] rem_q, rem_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            pulse_q, pulse_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tmr_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_wr) begin
          if (i_data != '0) begin
            state_d = HIGH;
            rem_d   = i_data;
            tmr_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      HIGH: begin
        if (tmr_q == HI_LAST) begin
          state_d = LOW;
          tmr_d   = '0;
          rem_d   = rem_q - 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      LOW: begin
        // Low phase always runs to completion so a downstream edge counter sees clean spacing.
        if (tmr_q == LO_LAST) begin
          tmr_d = '0;
          if (rem_q != '0) begin
            state_d = HIGH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    // Outputs are derived from the next state so they are registered yet cycle-aligned with it.
    pulse_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  assign o_pulse = pulse_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen (HI=2, LO=3): scoreboard of pulses-per-request plus cycle-exact waveform checks.
module tb_pulse_gen;
  localparam int BITS = 8;
  localparam int HI   = 2;
  localparam int LO   = 3;
  localparam int PER  = HI + LO;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            i_wr;
  logic [BITS-1:0] i_data;
  logic            o_pulse;
  logic            o_busy;
  logic            o_done;

  int errors = 0;
  int checks = 0;

  int exp_q[$];
  int obs_q[$];

  int         pcount   = 0;
  logic       prev     = 1'b0;
  logic [7:0] edge_cnt = 8'd0;

  always #5 clk = ~clk;

  pulse_gen #(
    .BITS      (BITS),
    .HI_CYCLES (HI),
    .LO_CYCLES (LO)
  ) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_wr    (i_wr),
    .i_data  (i_data),
    .o_pulse (o_pulse),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  // Edge-counting monitor: behaves like a downstream rising-edge counter.
  always @(negedge clk) begin
    if (i_rst === 1'b1) begin
      prev   = 1'b0;
      pcount = 0;
    end else begin
      if (o_pulse === 1'b1 && prev === 1'b0) begin
        pcount   = pcount + 1;
        edge_cnt = edge_cnt + 8'd1;
      end
      if (o_done === 1'b1) begin
        obs_q.push_back(pcount);
        pcount = 0;
      end
      prev = o_pulse;
    end
  end

  task automatic start(input int n);
    i_data = n[BITS-1:0];
    i_wr   = 1'b1;
    @(negedge clk);
    i_wr   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (o_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_pulse, o_busy, o_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: got %b want 000", {o_pulse, o_busy, o_done});
    end
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_pulse, o_busy, o_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got %b want 000", {o_pulse, o_busy, o_done});
    end
  endtask

  task automatic test_waveform;
    bit ep, eb, ed;
    int e, o;
    exp_q.push_back(3);
    start(3);
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) @(negedge clk);
      ep = (c <= 15) && (((c - 1) % PER) < HI);
      eb = (c <= 15);
      ed = (c == 16);
      checks++;
      if ({o_pulse, o_busy, o_done} !== {ep, eb, ed}) begin
        errors++;
        $display("FAIL wave c=%0d: pulse/busy/done got %b want %b", c, {o_pulse, o_busy, o_done}, {ep, eb, ed});
      end
    end
    #1;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_wave: obs=%0d exp=%0d entries", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL sb_wave: pulses got %0d want %0d", o, e);
      end
    end
  endtask

  task automatic test_zero;
    int e, o;
    @(negedge clk);
    exp_q.push_back(0);
    start(0);
    checks++;
    if ({o_pulse, o_busy, o_done} !== 3'b001) begin
      errors++;
      $display("FAIL zero_done: got %b want 001", {o_pulse, o_busy, o_done});
    end
    @(negedge clk);
    checks++;
    if ({o_pulse, o_busy, o_done} !== 3'b000) begin
      errors++;
      $display("FAIL zero_after: got %b want 000", {o_pulse, o_busy, o_done});
    end
    #1;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_zero: obs=%0d exp=%0d entries", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL sb_zero: pulses got %0d want %0d", o, e);
      end
    end
  endtask

  task automatic test_ignore_busy;
    bit ok;
    int cyc, e, o;
    @(negedge clk);
    exp_q.push_back(2);
    start(2);
    repeat (2) @(negedge clk);
    start(9);
    wait_done(50, ok, cyc);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_done: timeout got none want o_done");
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_busy: obs=%0d exp=%0d entries", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL sb_busy: pulses got %0d want %0d", o, e);
      end
    end
    checks++;
    if (obs_q.size() != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_extra: extra dones got %0d busy %b want 0 0", obs_q.size(), o_busy);
    end
  endtask

  task automatic test_max;
    bit ok;
    int cyc, e, o;
    @(negedge clk);
    exp_q.push_back(255);
    start(255);
    wait_done(2000, ok, cyc);
    checks++;
    if (!ok || cyc != 255 * PER || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL max_len: ok=%0d cycles got %0d want %0d busy=%b", ok, cyc, 255 * PER, o_busy);
    end
    #1;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_max: obs=%0d exp=%0d entries", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL sb_max: pulses got %0d want %0d", o, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int cyc, e, o;
    logic [7:0] base, diff;
    @(negedge clk);
    base = edge_cnt;
    exp_q.push_back(200);
    start(200);
    wait_done(1200, ok, cyc);
    #1;
    diff = edge_cnt - base;
    checks++;
    if (!ok || diff !== 8'd200) begin
      errors++;
      $display("FAIL loop_200: ok=%0d edges got %0d want 200", ok, diff);
    end
    exp_q.push_back(100);
    start(100);
    checks++;
    if ({o_pulse, o_busy} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_gap: pulse/busy got %b want 11", {o_pulse, o_busy});
    end
    wait_done(700, ok, cyc);
    #1;
    diff = edge_cnt - base;
    checks++;
    if (!ok || diff !== 8'd44) begin
      errors++;
      $display("FAIL loop_300: ok=%0d edges got %0d want 44", ok, diff);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_b2b%0d: obs=%0d exp=%0d entries", k, obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL sb_b2b%0d: pulses got %0d want %0d", k, o, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int cyc, e, o;
    @(negedge clk);
    start(5);
    repeat (5) @(negedge clk);
    checks++;
    if (o_pulse !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse2: pulse got %b want 1", o_pulse);
    end
    #1 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_pulse, o_busy, o_done} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset: got %b want 000", {o_pulse, o_busy, o_done});
    end
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_nodone: dones got %0d busy %b want 0 0", obs_q.size(), o_busy);
    end
    exp_q.push_back(1);
    start(1);
    wait_done(20, ok, cyc);
    checks++;
    if (!ok || cyc != PER) begin
      errors++;
      $display("FAIL mid_restart: ok=%0d cycles got %0d want %0d", ok, cyc, PER);
    end
    #1;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_mid: obs=%0d exp=%0d entries", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL sb_mid: pulses got %0d want %0d", o, e);
      end
    end
  endtask

  initial begin
    i_rst  = 1'b0;
    i_wr   = 1'b0;
    i_data = '0;
    test_reset;
    test_waveform;
    test_zero;
    test_ignore_busy;
    test_max;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
